// File: rtl/cpu_prog_feeder_pkg.sv
// -----------------------------------------------------------------------------
// cpu_prog_feeder_pkg
// Shared definitions for the CPU program feeder:
//   - state_t : feeder FSM states
//   - INSN_W  : instruction word width
//   - instruction field positions and opcode values of the lab CPU, plus small
//     encoder helpers so host-side code can build instruction words by name.
// -----------------------------------------------------------------------------
package cpu_prog_feeder_pkg;

    localparam int INSN_W = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_ACK,
        S_EXEC,
        S_CAPTURE,
        S_DONE,
        S_ERR
    } state_t;

    // Instruction field positions (bit ranges, inclusive).
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 13;
    localparam int OP_HI  = 12;
    localparam int OP_LO  = 11;
    localparam int RN_HI  = 10;
    localparam int RN_LO  = 8;
    localparam int RD_HI  = 7;
    localparam int RD_LO  = 5;
    localparam int SH_HI  = 4;
    localparam int SH_LO  = 3;
    localparam int RM_HI  = 2;
    localparam int RM_LO  = 0;

    // Opcode / op values.
    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    // MOV Rn,#imm8
    function automatic logic [INSN_W-1:0] enc_mov_imm(input logic [2:0] rn,
                                                      input logic [7:0] imm8);
        return {OPC_MOV, OP_MOV_IMM, rn, imm8};
    endfunction

    // MOV Rd,Rm{,<sh>}
    function automatic logic [INSN_W-1:0] enc_mov_reg(input logic [2:0] rd,
                                                      input logic [1:0] sh,
                                                      input logic [2:0] rm);
        return {OPC_MOV, OP_MOV_REG, 3'b000, rd, sh, rm};
    endfunction

    // ADD / CMP / AND / MVN with operands Rn, Rd, shifted Rm
    function automatic logic [INSN_W-1:0] enc_alu(input logic [1:0] op,
                                                  input logic [2:0] rn,
                                                  input logic [2:0] rd,
                                                  input logic [1:0] sh,
                                                  input logic [2:0] rm);
        return {OPC_ALU, op, rn, rd, sh, rm};
    endfunction

endpackage

// File: rtl/cpu_prog_feeder_prog_ram.sv
// -----------------------------------------------------------------------------
// cpu_prog_feeder_prog_ram
// Program store for the feeder: 2**AW words of INSN_W bits.
// Ports:
//   clk    - clock
//   we     - write enable (already qualified by the caller)
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - combinational read data at raddr
// -----------------------------------------------------------------------------
module cpu_prog_feeder_prog_ram
    import cpu_prog_feeder_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [INSN_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [INSN_W-1:0] rdata
);

    logic [INSN_W-1:0] mem [2**AW];

    // NOTE: storage arrays carry no reset; contents persist across a reset and
    // a reset loop over every word would turn the RAM into a bank of flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_prog_feeder.sv
// -----------------------------------------------------------------------------
// cpu_prog_feeder
// Host-side driver for the lab CPU instruction-load handshake. The host fills
// the program RAM, then pulses go; each instruction is presented on cpu_in,
// loaded with cpu_load, started with cpu_s, and the result is captured once
// cpu_w has fallen and risen again.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   prog_we/addr/data   - program RAM write port (ignored while busy)
//   go, len             - start a run of len instructions (clamped to DEPTH)
//   cpu_in/load/s       - instruction word and strobes towards the CPU
//   cpu_w, cpu_out,
//   cpu_N/V/Z           - CPU idle flag, result and status flags
//   busy, done, err     - run in progress, end-of-run pulse, sticky timeout
//   last_out, last_nzv  - result and {N,Z,V} of the last completed instruction
//   exec_count, pc      - instructions completed, index being issued
// -----------------------------------------------------------------------------
module cpu_prog_feeder
    import cpu_prog_feeder_pkg::*;
#(
    parameter int AW      = 4,
    parameter int TIMEOUT = 31,
    parameter int TW      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [INSN_W-1:0] prog_data,
    input  logic              go,
    input  logic [AW:0]       len,
    output logic [INSN_W-1:0] cpu_in,
    output logic              cpu_load,
    output logic              cpu_s,
    input  logic              cpu_w,
    input  logic [INSN_W-1:0] cpu_out,
    input  logic              cpu_N,
    input  logic              cpu_V,
    input  logic              cpu_Z,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [INSN_W-1:0] last_out,
    output logic [2:0]        last_nzv,
    output logic [AW:0]       exec_count,
    output logic [AW-1:0]     pc
);

    localparam int              DEPTH        = 2**AW;
    localparam logic [AW:0]     DEPTH_LEN    = DEPTH[AW:0];
    localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [TW-1:0]     tcnt_q;
    logic [AW:0]       len_q;
    logic [AW:0]       len_clamped;
    logic [AW:0]       exec_next;
    logic [INSN_W-1:0] ram_rdata;
    logic              waiting;
    logic              timeout_hit;
    logic              last_insn;

    cpu_prog_feeder_prog_ram #(.AW(AW)) u_prog_ram (
        .clk   (clk),
        .we    (prog_we && !busy),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (ram_rdata)
    );

    assign len_clamped = (len > DEPTH_LEN) ? DEPTH_LEN : len;
    assign exec_next   = exec_count + (AW+1)'(1);
    assign last_insn   = (exec_next == len_q);
    assign waiting     = (state_q inside {S_FETCH, S_ACK, S_EXEC});
    // The counter starts at 0 on entry, so hitting TIMEOUT-1 while still
    // waiting means TIMEOUT cycles have been spent in this wait state.
    assign timeout_hit = (tcnt_q == TIMEOUT_LAST);

    // Strobes and status decode straight from the state register, so a reset
    // edge silences them in the very next cycle.
    assign cpu_load = (state_q == S_LOAD);
    assign cpu_s    = (state_q == S_START);
    assign done     = (state_q == S_DONE) || (state_q == S_ERR);
    assign busy     = !(state_q inside {S_IDLE, S_DONE, S_ERR});

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (go) state_d = (len_clamped == '0) ? S_DONE : S_FETCH;
            S_FETCH:   if (cpu_w)            state_d = S_LOAD;
                       else if (timeout_hit) state_d = S_ERR;
            S_LOAD:    state_d = S_START;
            S_START:   state_d = S_ACK;
            S_ACK:     if (!cpu_w)           state_d = S_EXEC;
                       else if (timeout_hit) state_d = S_ERR;
            S_EXEC:    if (cpu_w)            state_d = S_CAPTURE;
                       else if (timeout_hit) state_d = S_ERR;
            S_CAPTURE: state_d = last_insn ? S_DONE : S_FETCH;
            S_DONE:    state_d = S_IDLE;
            S_ERR:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tcnt_q     <= '0;
            len_q      <= '0;
            cpu_in     <= '0;
            err        <= 1'b0;
            last_out   <= '0;
            last_nzv   <= '0;
            exec_count <= '0;
            pc         <= '0;
        end else begin
            state_q <= state_d;

            // Any state change restarts the wait budget for the next state.
            if (state_d != state_q) begin
                tcnt_q <= '0;
            end else if (waiting) begin
                tcnt_q <= tcnt_q + TW'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        err        <= 1'b0;
                        exec_count <= '0;
                        pc         <= '0;
                        len_q      <= len_clamped;
                    end
                end
                S_FETCH: begin
                    if (cpu_w) begin
                        cpu_in <= ram_rdata;
                    end
                end
                S_CAPTURE: begin
                    last_out   <= cpu_out;
                    last_nzv   <= {cpu_N, cpu_Z, cpu_V};
                    exec_count <= exec_next;
                    // pc stays on the final instruction so it never wraps.
                    if (!last_insn) begin
                        pc <= pc + AW'(1);
                    end
                end
                default: ;
            endcase

            // Raise err together with the done pulse of an aborted run.
            if (state_d == S_ERR) begin
                err <= 1'b1;
            end
        end
    end

endmodule
